// File: rtl/mor1kx_timer_sched_pkg.sv
// Shared constants and types for the tick-timer channel scheduler.
// Optional periodic re-arm is enabled by defining MOR1KX_TIMER_SCHED_PERIODIC_EN.
package mor1kx_timer_sched_pkg;

    localparam int unsigned DL_WIDTH_DEF  = 28;
    localparam int unsigned TTMR_PERIOD_W = 28;
    localparam int unsigned TTMR_IP_BIT   = 28;
    localparam int unsigned TTMR_IE_BIT   = 29;
    localparam int unsigned TTMR_MODE_LO  = 30;
    localparam int unsigned TTMR_MODE_HI  = 31;
    localparam logic [1:0]  TTMR_MODE_CONT = 2'b11;

    // Tick-timer mode register address, mirroring mor1kx-defines.v (group 10, reg 0)
    localparam logic [15:0] OR1K_SPR_TTMR_ADDR = 16'h5000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCAN     = 2'd1,
        ST_PROG     = 2'd2,
        ST_WAIT_ACK = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] dat;
    } spr_wr_t;

    // TTMR word: continuous mode, interrupt enabled, pending cleared, given period
    function automatic logic [31:0] ttmr_prog(input logic [TTMR_PERIOD_W-1:0] period);
        logic [31:0] w;
        w                              = 32'(period);
        w[TTMR_MODE_HI:TTMR_MODE_LO]   = TTMR_MODE_CONT;
        w[TTMR_IE_BIT]                 = 1'b1;
        w[TTMR_IP_BIT]                 = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/mor1kx_timer_sched_if.sv
// Arm handshake and tick-timer SPR write port of the scheduler.
// period_i exists only when MOR1KX_TIMER_SCHED_PERIODIC_EN is defined.
interface mor1kx_timer_sched_if
    import mor1kx_timer_sched_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DL_WIDTH = DL_WIDTH_DEF
) ();
    localparam int unsigned IDX_W = $clog2(NUM_CH);

    logic                set_valid_i;
    logic                set_ready_o;
    logic [IDX_W-1:0]    set_ch_i;
    logic [DL_WIDTH-1:0] set_deadline_i;
`ifdef MOR1KX_TIMER_SCHED_PERIODIC_EN
    logic [DL_WIDTH-1:0] period_i;
`endif
    logic                spr_we_o;
    logic [15:0]         spr_addr_o;
    logic [31:0]         spr_dat_o;
    logic                spr_ack_i;

    modport slave (
        input  set_valid_i, set_ch_i, set_deadline_i, spr_ack_i,
`ifdef MOR1KX_TIMER_SCHED_PERIODIC_EN
        input  period_i,
`endif
        output set_ready_o, spr_we_o, spr_addr_o, spr_dat_o
    );

    modport master (
        output set_valid_i, set_ch_i, set_deadline_i, spr_ack_i,
`ifdef MOR1KX_TIMER_SCHED_PERIODIC_EN
        output period_i,
`endif
        input  set_ready_o, spr_we_o, spr_addr_o, spr_dat_o
    );

endinterface

// File: rtl/mor1kx_timer_sched_dist.sv
// Distance from the free-running counter to one channel deadline, with late flag.
module mor1kx_timer_sched_dist #(
    parameter int unsigned DL_WIDTH = 28
) (
    input  logic [DL_WIDTH-1:0] deadline_i,
    input  logic [DL_WIDTH-1:0] now_i,
    output logic [DL_WIDTH-1:0] dist_c_o,
    output logic                late_c_o
);

    // Modular difference; top bit set means the deadline lies behind the counter
    assign dist_c_o = deadline_i - now_i;
    assign late_c_o = (dist_c_o == '0) || dist_c_o[DL_WIDTH-1];

endmodule

// File: rtl/mor1kx_timer_sched.sv
// Multiplexes NUM_CH virtual deadlines onto the single OR1K tick-timer match register.
// Define MOR1KX_TIMER_SCHED_PERIODIC_EN for per-channel periodic re-arm.
module mor1kx_timer_sched
    import mor1kx_timer_sched_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DL_WIDTH = DL_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    mor1kx_timer_sched_if.slave bus,
    input  logic [NUM_CH-1:0]   cancel_i,
    input  logic [31:0]         ttcr_i,
    input  logic [31:0]         ttmr_i,
    output logic [NUM_CH-1:0]   expired_o,
    input  logic [NUM_CH-1:0]   expired_clr_i,
    output logic                irq_o
);

    localparam int unsigned IDX_W = $clog2(NUM_CH);

    sched_state_e        state_q, state_d;
    logic [NUM_CH-1:0]   armed_q, armed_d;
    logic [NUM_CH-1:0]   expired_q, expired_d;
    logic [NUM_CH-1:0]   exp_set;
    logic [DL_WIDTH-1:0] dl_q [NUM_CH];
    logic [DL_WIDTH-1:0] dl_d [NUM_CH];
`ifdef MOR1KX_TIMER_SCHED_PERIODIC_EN
    logic [DL_WIDTH-1:0] per_q [NUM_CH];
    logic [DL_WIDTH-1:0] per_d [NUM_CH];
`endif
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic                best_valid_q, best_valid_d;
    logic [DL_WIDTH-1:0] best_dist_q, best_dist_d;
    logic [DL_WIDTH-1:0] best_dl_q, best_dl_d;
    logic                rescan_q, rescan_d;
    logic                set_ready_q, set_ready_d;
    logic                spr_we_q, spr_we_d;
    spr_wr_t             spr_q, spr_d;
    logic                irq_q;

    logic [DL_WIDTH-1:0] dist_c [NUM_CH];
    logic [NUM_CH-1:0]   late_c;
    logic                unused_c;

    assign unused_c = ^{ttcr_i, ttmr_i};

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_dist
        mor1kx_timer_sched_dist #(
            .DL_WIDTH (DL_WIDTH)
        ) u_dist (
            .deadline_i (dl_q[g]),
            .now_i      (ttcr_i[DL_WIDTH-1:0]),
            .dist_c_o   (dist_c[g]),
            .late_c_o   (late_c[g])
        );
    end

    // Next-state, channel bookkeeping and SPR write generation
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        dl_d         = dl_q;
`ifdef MOR1KX_TIMER_SCHED_PERIODIC_EN
        per_d        = per_q;
`endif
        exp_set      = '0;
        scan_idx_d   = scan_idx_q;
        best_idx_d   = best_idx_q;
        best_valid_d = best_valid_q;
        best_dist_d  = best_dist_q;
        best_dl_d    = best_dl_q;
        rescan_d     = rescan_q;
        spr_we_d     = spr_we_q;
        spr_d        = spr_q;

        case (state_q)
            ST_IDLE: begin
                if (ttmr_i[TTMR_IP_BIT]) begin
                    for (int c = 0; c < int'(NUM_CH); c++) begin
                        if (armed_q[c] && (dl_q[c] == ttmr_i[DL_WIDTH-1:0])) begin
                            exp_set[c] = 1'b1;
`ifdef MOR1KX_TIMER_SCHED_PERIODIC_EN
                            if (per_q[c] != '0) begin
                                dl_d[c] = dl_q[c] + per_q[c];
                            end else begin
                                armed_d[c] = 1'b0;
                            end
`else
                            armed_d[c] = 1'b0;
`endif
                        end
                    end
                    state_d = ST_SCAN;
                end
                // A fresh arm overrides an expiry of the same channel in this cycle
                if (bus.set_valid_i && set_ready_q) begin
                    if (32'(bus.set_ch_i) < NUM_CH) begin
                        armed_d[bus.set_ch_i] = 1'b1;
                        dl_d[bus.set_ch_i]    = bus.set_deadline_i;
`ifdef MOR1KX_TIMER_SCHED_PERIODIC_EN
                        per_d[bus.set_ch_i]   = bus.period_i;
`endif
                    end
                    state_d = ST_SCAN;
                end
                if (state_d == ST_SCAN) begin
                    scan_idx_d   = '0;
                    best_valid_d = 1'b0;
                    rescan_d     = 1'b0;
                end
            end

            ST_SCAN: begin
                if (armed_q[scan_idx_q] && !cancel_i[scan_idx_q]) begin
                    if (late_c[scan_idx_q]) begin
                        exp_set[scan_idx_q] = 1'b1;
`ifdef MOR1KX_TIMER_SCHED_PERIODIC_EN
                        if (per_q[scan_idx_q] != '0) begin
                            dl_d[scan_idx_q] = dl_q[scan_idx_q] + per_q[scan_idx_q];
                            rescan_d         = 1'b1;
                        end else begin
                            armed_d[scan_idx_q] = 1'b0;
                        end
`else
                        armed_d[scan_idx_q] = 1'b0;
`endif
                    end else if (!best_valid_q || (dist_c[scan_idx_q] < best_dist_q)) begin
                        best_valid_d = 1'b1;
                        best_idx_d   = scan_idx_q;
                        best_dist_d  = dist_c[scan_idx_q];
                        best_dl_d    = dl_q[scan_idx_q];
                    end
                end
                if (scan_idx_q == IDX_W'(NUM_CH - 1)) begin
                    // A winner cancelled mid-scan, or a re-armed deadline, forces another pass
                    if (rescan_d || (best_valid_d &&
                                     (!armed_q[best_idx_d] || cancel_i[best_idx_d]))) begin
                        scan_idx_d   = '0;
                        best_valid_d = 1'b0;
                        rescan_d     = 1'b0;
                    end else begin
                        state_d    = ST_PROG;
                        spr_we_d   = 1'b1;
                        spr_d.addr = OR1K_SPR_TTMR_ADDR;
                        spr_d.dat  = best_valid_d ? ttmr_prog(TTMR_PERIOD_W'(best_dl_d)) : '0;
                    end
                end else begin
                    scan_idx_d = scan_idx_q + IDX_W'(1);
                end
            end

            ST_PROG: begin
                if (bus.spr_ack_i) begin
                    spr_we_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_WAIT_ACK;
                end
            end

            ST_WAIT_ACK: begin
                if (bus.spr_ack_i) begin
                    spr_we_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        armed_d     = armed_d & ~cancel_i;
        expired_d   = (expired_q & ~expired_clr_i) | exp_set;
        set_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            armed_q      <= '0;
            expired_q    <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                dl_q[c]  <= '0;
`ifdef MOR1KX_TIMER_SCHED_PERIODIC_EN
                per_q[c] <= '0;
`endif
            end
            scan_idx_q   <= '0;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
            best_dist_q  <= '0;
            best_dl_q    <= '0;
            rescan_q     <= 1'b0;
            set_ready_q  <= 1'b1;
            spr_we_q     <= 1'b0;
            spr_q        <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            expired_q    <= expired_d;
            dl_q         <= dl_d;
`ifdef MOR1KX_TIMER_SCHED_PERIODIC_EN
            per_q        <= per_d;
`endif
            scan_idx_q   <= scan_idx_d;
            best_idx_q   <= best_idx_d;
            best_valid_q <= best_valid_d;
            best_dist_q  <= best_dist_d;
            best_dl_q    <= best_dl_d;
            rescan_q     <= rescan_d;
            set_ready_q  <= set_ready_d;
            spr_we_q     <= spr_we_d;
            spr_q        <= spr_d;
            irq_q        <= |expired_q;
        end
    end

    assign bus.set_ready_o = set_ready_q;
    assign bus.spr_we_o    = spr_we_q;
    assign bus.spr_addr_o  = spr_q.addr;
    assign bus.spr_dat_o   = spr_q.dat;
    assign expired_o       = expired_q;
    assign irq_o           = irq_q;

endmodule
